// File: rtl/data_mem_responder.sv
// Handshaked data-memory slave: accepts one load/store, waits LATENCY cycles,
// performs a little-endian byte/half/word access and holds the response until taken.
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAST = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          fault;
  logic [31:0]   word;
  logic [31:0]   shifted;
  logic [15:0]   half;
  logic [31:0]   loadData;
  logic [3:0]    wmask;
  logic [31:0]   wword;
  logic          doAccess;
  logic          memWrite;

  assign idx     = addr_q[AW+1:2];
  assign lane    = addr_q[1:0];
  assign word    = mem[idx];
  assign shifted = word >> {lane, 3'b000};
  assign half    = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    fault = 1'b0;
    case (size_q)
      2'b01:   fault = lane[0];
      2'b10:   fault = (lane != 2'b00);
      2'b11:   fault = 1'b1;
      default: fault = 1'b0;
    endcase
    if ({2'b00, addr_q[31:2]} >= 32'(DEPTH)) fault = 1'b1;
  end

  always_comb begin
    loadData = word;
    case (size_q)
      2'b00:   loadData = uns_q ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   loadData = uns_q ? {16'd0, half} : {{16{half[15]}}, half};
      default: loadData = word;
    endcase
  end

  // Store data is replicated across lanes so the byte mask alone picks the target bytes.
  always_comb begin
    wmask = 4'b1111;
    wword = wdata_q;
    case (size_q)
      2'b00: begin
        wmask = 4'b0001 << lane;
        wword = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wmask = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata_q[15:0]}};
      end
      default: begin
        wmask = 4'b1111;
        wword = wdata_q;
      end
    endcase
  end

  assign doAccess = (state_q == WAIT) && (cnt_q == LAST);
  assign memWrite = doAccess && we_q && !fault;

  always_ff @(posedge clk) begin
    if (memWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    size_d    = size_q;
    uns_d     = uns_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          cnt_d   = 4'd0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (doAccess) begin
          rdata_d = (we_q || fault) ? 32'd0 : loadData;
          err_d   = fault;
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed and random transactions checked
// against a byte-addressed reference memory.
module tb_data_mem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;

  logic [7:0] modelMem [4*DEPTH];

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference: faults by alignment/range, then byte-wise access with arithmetic sign extension.
  function automatic void modelAccess(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                      input logic uns, input logic [31:0] wdata,
                                      output logic [31:0] expData, output logic expErr);
    int nBytes;
    logic [31:0] value;
    nBytes  = 1 << size;
    expErr  = (size == 2'b11) || ((addr % nBytes) != 0) || ((addr / 4) >= DEPTH);
    expData = 32'd0;
    if (expErr) return;
    if (we) begin
      for (int i = 0; i < nBytes; i++) modelMem[addr + i] = wdata[8*i +: 8];
    end else begin
      value = 32'd0;
      for (int i = 0; i < nBytes; i++) value = value | (32'(modelMem[addr + i]) << (8 * i));
      if (!uns && nBytes < 4 && value >= 32'(1 << (8 * nBytes - 1)))
        value = value - 32'(1 << (8 * nBytes));
      expData = value;
    end
  endfunction

  // Must be entered just after a falling edge; returns just after a falling edge.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                               input logic uns, input logic [31:0] wdata, input int holdCycles,
                               input logic holdReq, input logic checkData,
                               output int acceptCycle, output logic [31:0] obsData);
    logic [31:0] expData;
    logic        expErr;
    int          waited;
    expData     = 32'd0;
    expErr      = 1'b0;
    acceptCycle = 0;
    obsData     = 32'd0;
    if (checkData) modelAccess(we, addr, size, uns, wdata, expData, expErr);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    rsp_ready    = (holdCycles == 0);
    waited = 0;
    while (!req_ready && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checkOutput("acceptTimeout", 32'd1, 32'd0);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    acceptCycle = cycle;
    checkOutput("readyDropped", 32'(req_ready), 32'd0);
    if (!holdReq) begin
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_we    = ~we;
      req_size  = 2'($urandom_range(0, 3));
    end
    waited = 1;
    while (!rsp_valid && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    if (!rsp_valid) begin
      checkOutput("responseTimeout", 32'd1, 32'd0);
      req_valid = 1'b0;
      return;
    end
    checkOutput("rspLatency", 32'(waited), 32'(LATENCY + 1));
    obsData = rsp_rdata;
    if (checkData) begin
      checkOutput("rdata", rsp_rdata, expData);
      checkOutput("err", 32'(rsp_err), 32'(expErr));
    end
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkOutput("holdValid", 32'(rsp_valid), 32'd1);
      checkOutput("holdReqReady", 32'(req_ready), 32'd0);
      if (checkData) begin
        checkOutput("holdRdata", rsp_rdata, expData);
        checkOutput("holdErr", 32'(rsp_err), 32'(expErr));
      end
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rspConsumed", 32'(rsp_valid), 32'd0);
    checkOutput("readyBack", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int          acc;
    int          prevAcc;
    logic [31:0] obs;
    logic [31:0] a;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = 32'd0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_wdata    = 32'd0;
    rsp_ready    = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("resetReqReady", 32'(req_ready), 32'd1);
    checkOutput("resetRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("resetRdata", rsp_rdata, 32'd0);
    checkOutput("resetErr", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset during WAIT of a store");
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h10;
    req_size  = 2'b10;
    req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("waitEntered", 32'(req_ready), 32'd0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rstReqReady", 32'(req_ready), 32'd1);
      checkOutput("rstRspValid", 32'(rsp_valid), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postRstReqReady", 32'(req_ready), 32'd1);
    checkOutput("postRstRspValid", 32'(rsp_valid), 32'd0);
    applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'd0, 0, 1'b0, 1'b0, acc, obs);
    checkOutput("abortedStoreNotWritten", 32'(obs !== 32'hDEADBEEF), 32'd1);

    $display("[TB] word round trip and sub-word accesses");
    applyStimulus(1'b1, 32'h20, 2'b10, 1'b0, 32'h12345678, 0, 1'b0, 1'b1, acc, obs);
    applyStimulus(1'b0, 32'h20, 2'b10, 1'b0, 32'd0, 0, 1'b0, 1'b1, acc, obs);
    checkOutput("wordRoundTrip", obs, 32'h12345678);
    applyStimulus(1'b1, 32'h21, 2'b00, 1'b0, {24'($urandom), 8'hAB}, 0, 1'b0, 1'b1, acc, obs);
    applyStimulus(1'b0, 32'h20, 2'b10, 1'b0, 32'd0, 0, 1'b0, 1'b1, acc, obs);
    checkOutput("byteMerged", obs, 32'h1234AB78);
    applyStimulus(1'b0, 32'h21, 2'b00, 1'b0, 32'd0, 0, 1'b0, 1'b1, acc, obs);
    checkOutput("byteSigned", obs, 32'hFFFFFFAB);
    applyStimulus(1'b0, 32'h21, 2'b00, 1'b1, 32'd0, 0, 1'b0, 1'b1, acc, obs);
    checkOutput("byteUnsigned", obs, 32'h000000AB);
    applyStimulus(1'b0, 32'h22, 2'b01, 1'b0, 32'd0, 0, 1'b0, 1'b1, acc, obs);
    checkOutput("halfSigned", obs, 32'h00001234);

    $display("[TB] faults");
    applyStimulus(1'b0, 32'h23, 2'b01, 1'b0, 32'd0, 0, 1'b0, 1'b1, acc, obs);
    applyStimulus(1'b1, 32'h22, 2'b10, 1'b0, 32'hCAFEF00D, 0, 1'b0, 1'b1, acc, obs);
    applyStimulus(1'b0, 32'h20, 2'b11, 1'b0, 32'd0, 0, 1'b0, 1'b1, acc, obs);
    applyStimulus(1'b0, 32'(4 * DEPTH), 2'b10, 1'b0, 32'd0, 0, 1'b0, 1'b1, acc, obs);
    applyStimulus(1'b0, 32'h20, 2'b10, 1'b0, 32'd0, 0, 1'b0, 1'b1, acc, obs);
    checkOutput("faultNoWrite", obs, 32'h1234AB78);

    $display("[TB] backpressure");
    applyStimulus(1'b0, 32'h20, 2'b10, 1'b0, 32'd0, 5, 1'b1, 1'b1, acc, obs);

    $display("[TB] back-to-back alternating stores and loads");
    prevAcc = 0;
    for (int k = 0; k < 8; k++) begin
      a = 32'h40 + 32'(4 * (k / 2));
      applyStimulus(k[0] ? 1'b0 : 1'b1, a, 2'b10, 1'b0, $urandom, 0, 1'b0, 1'b1, acc, obs);
      if (k > 0) checkOutput("acceptSpacing", 32'(acc - prevAcc), 32'(LATENCY + 2));
      prevAcc = acc;
    end

    $display("[TB] random traffic");
    for (int k = 0; k < 16; k++)
      applyStimulus(1'b1, 32'h100 + 32'(4 * k), 2'b10, 1'b0, $urandom, 0, 1'b0, 1'b1, acc, obs);
    for (int k = 0; k < 48; k++) begin
      if ($urandom_range(0, 7) == 0) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
      else a = 32'h100 + 32'($urandom_range(0, 63));
      applyStimulus(1'($urandom), a, 2'($urandom_range(0, 3)), 1'($urandom), $urandom,
                    int'($urandom_range(0, 3)), 1'($urandom), 1'b1, acc, obs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's load/store port: accepts one request at a time over a valid/ready handshake, waits a programmable number of cycles, performs a byte/half/word access on a little-endian word array, and returns a response over a second valid/ready handshake. It is the slave end of the data-memory interface and replaces the zero-latency combinational data memory once the core moves to a handshaked load/store unit.

## Interface
- DEPTH, 1024: number of 32-bit words in the array.
- LATENCY, 2: wait cycles between request acceptance and response. Legal range is 1..15.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  load zero-extends when 1 and sign-extends when 0. Ignored for stores.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes the response.
- rsp_rdata  out  32  load result, extended to 32 bits. 0 for stores and errors.
- rsp_err  out  1  access faulted; no array update occurred.

## Operation
- FSM states and transitions:
  - IDLE: req_ready=1. Moves to WAIT on req_valid&&req_ready.
  - WAIT: counts LATENCY cycles, then moves to RESP.
  - RESP: rsp_valid=1. Moves to IDLE on rsp_ready.
- On acceptance, register we, addr, size, unsigned and wdata. The request inputs are don't-care after that.
- Fault if any of the following holds:
  - size==11.
  - half access with addr[0]=1.
  - word access with addr[1:0]!=0.
  - addr[31:2] >= DEPTH.
- A fault sets rsp_err=1 and rsp_rdata=0. A faulting store does not write.
- Word index is addr[31:2]. Byte lane is addr[1:0], little-endian: lane 0 = bits [7:0].
- Store byte: write only lane addr[1:0] with wdata[7:0].
- Store half: write lanes addr[1]*2 and addr[1]*2+1 with wdata[15:0].
- Store word: write all lanes.
- Load: select the lane(s), then sign-extend or zero-extend per the latched unsigned bit. Word loads are unaffected by unsigned.
- Array contents are not touched by rst. Only control state resets.

## Timing
- Reset values:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
- Request accepted at rising edge t. req_ready falls after t.
- The array write and the read-data/err capture happen at edge t+LATENCY. rsp_valid rises after that edge.
- rsp_rdata and rsp_err stay stable while rsp_valid=1 and rsp_ready=0.
- Response consumed at the edge where rsp_valid&&rsp_ready. rsp_valid falls and req_ready rises after that edge.
- A new request can be accepted no earlier than the edge after the consuming edge.
- Request-to-request throughput is LATENCY+2 cycles when rsp_ready is held high.
- rsp_ready may already be high when rsp_valid rises. The response is then consumed at the next edge, and rsp_valid lasts exactly one cycle.
- req_valid asserted outside IDLE is ignored and is not queued. The requester must hold it until req_ready.
- Asserting rst mid-WAIT aborts the access with no write. Asserting rst mid-RESP drops the response. After rst deasserts, the block is in IDLE.
- A load from a location written by the immediately preceding store returns the new data.

## Test plan
- Reset: assert rst for 3 cycles mid-WAIT of a store of 0xDEADBEEF to 0x10, then load 0x10. Expect req_ready=1 and rsp_valid=0 during and after reset, and the load does not return 0xDEADBEEF.
- Word round trip: store 0x12345678 to 0x20, then load 0x20. Expect rsp_rdata=0x12345678, rsp_err=0, and rsp_valid rising exactly LATENCY+1 cycles after the accept cycle.
- Sub-word stores and loads:
  - After the word 0x12345678 at 0x20, store byte 0xAB to 0x21, giving word 0x1234AB78.
  - Signed byte load at 0x21 returns 0xFFFFFFAB; unsigned returns 0x000000AB.
  - Signed half load at 0x22 returns 0x00001234.
- Faults:
  - Half load at 0x23 returns rsp_err=1, rsp_rdata=0.
  - Word store to 0x22 returns rsp_err=1 and memory is unchanged.
  - size=11 returns rsp_err=1.
  - Address 4*DEPTH returns rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid. Expect rsp_valid, rsp_rdata and rsp_err stable and req_ready=0 throughout, with req_valid held high and not accepted.
- Back-to-back with rsp_ready tied high: 8 alternating stores and loads. Expect each accept exactly LATENCY+2 cycles apart and all data correct.
